mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage access controller between the EX/MEM pipeline register and data_memory (word-addressed, 2**ADDR_SIZE slots of SLOT_SIZE bits, combinational read, write on clock edge when i_wr_rd=1).
- Translates MIPS byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW into word accesses.
- Sub-word stores are done as read-modify-write, with a pipeline stall.
- Produces sign- or zero-extended load data and flags misaligned accesses.

Parameters:
ADDR_SIZE, 5, word-address width of data_memory
SLOT_SIZE, 32, data_memory word width; only 32 is supported

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  pipeline flush; aborts the operation in progress
i_req_valid  in  1  access request present
i_mem_wr  in  1  store request
i_mem_rd  in  1  load request
i_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (treated as word)
i_unsigned  in  1  zero-extend loads (LBU/LHU)
i_addr  in  32  byte address
i_wr_data  in  32  store data; byte/half taken from LSBs
i_mem_data  in  SLOT_SIZE  data_memory o_data
o_mem_wr_rd  out  1  data_memory i_wr_rd
o_mem_addr  out  ADDR_SIZE  data_memory i_addr
o_mem_data  out  SLOT_SIZE  data_memory i_data
o_rd_data  out  32  registered, extended load result
o_done  out  1  one-cycle pulse: access completed
o_misaligned  out  1  one-cycle pulse, coincident with o_done
o_stall  out  1  upstream must hold its request stable

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous and active-high.
- Reset values: state=IDLE, o_rd_data=0, o_done=0, o_misaligned=0, merge register=0.
- Reset also drives the combinational outputs to: o_mem_wr_rd=0, o_stall=0, o_mem_addr=0, o_mem_data=0.
- Addressing:
  - Word index = i_addr[ADDR_SIZE+1:2]; upper bits are ignored, so addresses wrap modulo the memory size.
  - Lane = i_addr[1:0]. Little-endian: lane 0 is bits 7:0.
- Alignment: misaligned if (half and addr[0]=1) or (word and addr[1:0]!=0). A misaligned access:
  - makes no memory write;
  - leaves o_rd_data unchanged;
  - pulses o_done and o_misaligned on the next cycle.
- Request decode: accepted in IDLE when i_req_valid=1 and i_flush=0.
  - If i_mem_wr=1 it is a store, even if i_mem_rd=1.
  - If i_mem_wr=0 and i_mem_rd=0 it is ignored.
- States:
  - IDLE: accepts requests.
  - RMW_WRITE: second cycle of a sub-word store.
- Load (IDLE, 1 cycle):
  - o_mem_addr is driven from i_addr combinationally.
  - The lane is selected from i_mem_data and extended (sign unless i_unsigned), then registered into o_rd_data.
  - o_done pulses at the next cycle. o_stall=0.
- Word store (IDLE, 1 cycle): o_mem_wr_rd=1, o_mem_data=i_wr_data. The memory writes at that edge; o_done pulses next cycle. o_stall=0.
- Sub-word store (2 cycles):
  - IDLE cycle:
    - read the word, replace the byte/half lane with i_wr_data LSBs, latch into the merge register;
    - latch the word index;
    - o_stall=1, o_mem_wr_rd=0, go to RMW_WRITE.
  - RMW_WRITE cycle: o_mem_wr_rd=1, o_mem_addr=latched index, o_mem_data=merge register, o_stall=1. Go to IDLE; o_done pulses next cycle.
- Flush:
  - i_flush=1 in IDLE: the request is ignored.
  - i_flush=1 in RMW_WRITE: the write is suppressed (o_mem_wr_rd=0), state goes to IDLE, no o_done.
  - o_done/o_misaligned already scheduled for the next cycle are cleared.
- Reset mid-RMW: the next state is IDLE and no write occurs; o_mem_wr_rd is forced 0 during the reset cycle.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after RMW_WRITE (the cycle o_done pulses). Throughput is 1 access/cycle for loads and word stores.
- The data_memory i_flush port is driven outside this block.

Test Plan:
- Preload word[3]=0x8899AABB.
  - LB addr 0x0D -> o_rd_data=0xFFFFFFAA, o_done 1 cycle later.
  - LBU addr 0x0D -> 0x000000AA.
  - LH addr 0x0E -> 0xFFFF8899.
  - LHU addr 0x0E -> 0x00008899.
- SB data 0x11 addr 0x0F:
  - o_stall high 2 cycles;
  - write in cycle 2 with o_mem_data=0x1199AABB;
  - o_done cycle 3;
  - LW 0x0C -> 0x1199AABB.
- SH 0xCAFE addr 0x0C -> word[3]=0x8899CAFE. SW 0xDEADBEEF addr 0x80 -> wraps to word[0] (ADDR_SIZE=5).
- LW addr 0x0E and SH addr 0x0D:
  - o_misaligned and o_done pulse;
  - no o_mem_wr_rd;
  - word[3] unchanged and o_rd_data unchanged.
- Edge cases:
  - SB started, then i_flush=1 in RMW_WRITE -> no write, no o_done, word unchanged.
  - Same with i_reset=1 instead -> outputs return to reset values, word unchanged.
- Back-to-back: SB, then LW to the same word in the o_done cycle -> the load returns the merged value.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage access controller: byte/half/word loads and stores,
// sub-word stores as a two-cycle read-modify-write against a word-addressed data memory.
module mem_access_unit #(
   parameter int ADDR_SIZE = 5,
   parameter int SLOT_SIZE = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_flush,
   input  logic                 i_req_valid,
   input  logic                 i_mem_wr,
   input  logic                 i_mem_rd,
   input  logic [1:0]           i_size,
   input  logic                 i_unsigned,
   input  logic [31:0]          i_addr,
   input  logic [31:0]          i_wr_data,
   input  logic [SLOT_SIZE-1:0] i_mem_data,
   output logic                 o_mem_wr_rd,
   output logic [ADDR_SIZE-1:0] o_mem_addr,
   output logic [SLOT_SIZE-1:0] o_mem_data,
   output logic [31:0]          o_rd_data,
   output logic                 o_done,
   output logic                 o_misaligned,
   output logic                 o_stall
);

   typedef enum logic {IDLE, RMW_WRITE} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            merge_q, merge_d;
   logic [31:0]            rd_data_q, rd_data_d;
   logic [ADDR_SIZE-1:0]   idx_q, idx_d;
   logic                   done_q, done_d;
   logic                   mis_q, mis_d;

   logic [ADDR_SIZE-1:0]   word_idx;
   logic [1:0]             lane;
   logic                   misaligned;
   logic                   accept;
   logic [7:0]             lane_byte;
   logic [15:0]            lane_half;
   logic [31:0]            load_ext;
   logic [31:0]            merged;

   assign word_idx = i_addr[ADDR_SIZE+1:2];
   assign lane     = i_addr[1:0];
   assign accept   = i_req_valid && !i_flush && (i_mem_wr || i_mem_rd);

   always_comb begin
      misaligned = 1'b0;
      case (i_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = i_addr[0];
         default: misaligned = |i_addr[1:0];
      endcase
   end

   // Load path: pick the addressed lane, then sign- or zero-extend it.
   always_comb begin
      lane_byte = i_mem_data[{lane, 3'b000} +: 8];
      lane_half = i_addr[1] ? i_mem_data[31:16] : i_mem_data[15:0];
      case (i_size)
         2'b00:   load_ext = {{24{~i_unsigned & lane_byte[7]}}, lane_byte};
         2'b01:   load_ext = {{16{~i_unsigned & lane_half[15]}}, lane_half};
         default: load_ext = i_mem_data;
      endcase
   end

   // Store merge: the current word with only the addressed lane replaced.
   always_comb begin
      merged = i_mem_data;
      if (i_size == 2'b00) begin
         merged[{lane, 3'b000} +: 8] = i_wr_data[7:0];
      end else begin
         merged[{i_addr[1], 4'b0000} +: 16] = i_wr_data[15:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      merge_d     = merge_q;
      idx_d       = idx_q;
      rd_data_d   = rd_data_q;
      done_d      = 1'b0;
      mis_d       = 1'b0;
      o_mem_wr_rd = 1'b0;
      o_mem_addr  = word_idx;
      o_mem_data  = i_wr_data;
      o_stall     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  done_d = 1'b1;
                  mis_d  = 1'b1;
               end else if (i_mem_wr) begin
                  if (!i_size[1]) begin
                     merge_d = merged;
                     idx_d   = word_idx;
                     o_stall = 1'b1;
                     state_d = RMW_WRITE;
                  end else begin
                     o_mem_wr_rd = 1'b1;
                     done_d      = 1'b1;
                  end
               end else begin
                  rd_data_d = load_ext;
                  done_d    = 1'b1;
               end
            end
         end
         RMW_WRITE: begin
            o_mem_addr = idx_q;
            o_mem_data = merge_q;
            o_stall    = 1'b1;
            state_d    = IDLE;
            if (!i_flush) begin
               o_mem_wr_rd = 1'b1;
               done_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset must never let a half-finished RMW reach memory.
      if (i_reset) begin
         o_mem_wr_rd = 1'b0;
         o_stall     = 1'b0;
         o_mem_addr  = '0;
         o_mem_data  = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         merge_q   <= '0;
         idx_q     <= '0;
         rd_data_q <= '0;
         done_q    <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         merge_q   <= merge_d;
         idx_q     <= idx_d;
         rd_data_q <= rd_data_d;
         done_q    <= done_d;
         mis_q     <= mis_d;
      end
   end

   assign o_rd_data    = rd_data_q;
   assign o_done       = done_q;
   assign o_misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed checks of mem_access_unit
// against a byte-lane reference model of the data memory.
module tb_mem_access_unit;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          req_valid;
   logic          mem_wr;
   logic          mem_rd;
   logic [1:0]    size;
   logic          uns;
   logic [31:0]   addr;
   logic [31:0]   wr_data;
   logic [31:0]   mem_rdata;
   logic          mem_wr_rd;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   rd_data;
   logic          done;
   logic          mis;
   logic          stall;

   logic [31:0]   mem     [0:31];
   logic [31:0]   ref_mem [0:31];
   logic [31:0]   ref_rd;

   int            pass_cnt = 0;
   int            total    = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_SIZE(AW), .SLOT_SIZE(32)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_flush      (flush),
      .i_req_valid  (req_valid),
      .i_mem_wr     (mem_wr),
      .i_mem_rd     (mem_rd),
      .i_size       (size),
      .i_unsigned   (uns),
      .i_addr       (addr),
      .i_wr_data    (wr_data),
      .i_mem_data   (mem_rdata),
      .o_mem_wr_rd  (mem_wr_rd),
      .o_mem_addr   (mem_addr),
      .o_mem_data   (mem_wdata),
      .o_rd_data    (rd_data),
      .o_done       (done),
      .o_misaligned (mis),
      .o_stall      (stall)
   );

   // Data memory: combinational read, write on the clock edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_wr_rd) mem[mem_addr] <= mem_wdata;

   task automatic preload(input int idx, input logic [31:0] val);
      mem[idx] <= val;
      ref_mem[idx] = val;
   endtask

   // Reference: architectural effect of one MIPS access on a byte-addressed view.
   task automatic model(input logic wr, input logic rd, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic e_done, output logic e_mis, output int e_stall, output int e_wr);
      int idx;
      int sh;
      logic [31:0] w;
      logic bad;
      idx = int'(a[AW+1:2]);
      bad = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
      e_done = 1'b0; e_mis = 1'b0; e_stall = 0; e_wr = 0;
      if (!wr && !rd) return;
      e_done = 1'b1;
      e_mis  = bad;
      if (bad) return;
      if (wr) begin
         e_wr = 1;
         if (sz == 2'd0) begin
            sh = int'(a[1:0]) * 8;
            ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            e_stall = 2;
         end else if (sz == 2'd1) begin
            sh = int'(a[1]) * 16;
            ref_mem[idx] = (ref_mem[idx] & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            e_stall = 2;
         end else begin
            ref_mem[idx] = wd;
         end
      end else begin
         if (sz == 2'd0) begin
            w = ref_mem[idx] >> (int'(a[1:0]) * 8);
            ref_rd = (w & 32'hFF) | ((!u && w[7]) ? 32'hFFFFFF00 : 32'h0);
         end else if (sz == 2'd1) begin
            w = ref_mem[idx] >> (int'(a[1]) * 16);
            ref_rd = (w & 32'hFFFF) | ((!u && w[15]) ? 32'hFFFF0000 : 32'h0);
         end else begin
            ref_rd = ref_mem[idx];
         end
      end
   endtask

   // Drives one request, holding it through any stall, and reports what was seen.
   task automatic do_access(input logic wr, input logic rd, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic o_d, output logic o_m, output int n_stall, output int n_wr,
                            output logic [31:0] last_wdata, output logic timed_out);
      logic last;
      @(negedge clk);
      req_valid = 1'b1; mem_wr = wr; mem_rd = rd; size = sz; uns = u; addr = a; wr_data = wd;
      n_stall = 0; n_wr = 0; last_wdata = 32'h0; timed_out = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (stall) n_stall++;
         if (mem_wr_rd) begin
            n_wr++;
            last_wdata = mem_wdata;
         end
         last = !stall || (n_stall == 2);
         @(posedge clk);
         if (last) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0;
      #1;
      o_d = done;
      o_m = mis;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      req_valid = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0; size = 2'd0; uns = 1'b0;
      addr = 32'h1F; wr_data = 32'h1234_5678;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      total++; if (mem_wr_rd !== 1'b0) $display("FAIL reset_wr_rd got %b want 0", mem_wr_rd); else pass_cnt++;
      total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
      total++; if (mem_addr !== 5'd0) $display("FAIL reset_addr got %h want 0", mem_addr); else pass_cnt++;
      total++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", mem_wdata); else pass_cnt++;
      total++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", rd_data); else pass_cnt++;
      total++; if (done !== 1'b0 || mis !== 1'b0) $display("FAIL reset_done_mis got %b%b want 00", done, mis); else pass_cnt++;
      rst = 1'b0; req_valid = 1'b0; mem_wr = 1'b0;
      ref_rd = 32'h0;
   endtask

   task automatic test_loads();
      logic [1:0]  szs  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        us   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] as   [4] = '{32'h0D, 32'h0D, 32'h0E, 32'h0E};
      logic [31:0] want [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
      logic d, m, e_d, e_m, to;
      int ns, nw, es, ew;
      logic [31:0] lw;
      @(negedge clk);
      preload(3, 32'h8899AABB);
      for (int i = 0; i < 4; i++) begin
         model(1'b0, 1'b1, szs[i], us[i], as[i], 32'h0, e_d, e_m, es, ew);
         do_access(1'b0, 1'b1, szs[i], us[i], as[i], 32'h0, d, m, ns, nw, lw, to);
         total++; if (rd_data !== want[i] || ref_rd !== want[i]) $display("FAIL load%0d_data got %h want %h", i, rd_data, want[i]); else pass_cnt++;
         total++; if (d !== 1'b1 || m !== 1'b0 || to !== 1'b0) $display("FAIL load%0d_done got %b%b%b want 100", i, d, m, to); else pass_cnt++;
      end
   endtask

   task automatic test_sub_store();
      logic d, m, e_d, e_m, to;
      int ns, nw, es, ew;
      logic [31:0] lw;
      model(1'b1, 1'b0, 2'd0, 1'b0, 32'h0F, 32'h11, e_d, e_m, es, ew);
      do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0F, 32'h11, d, m, ns, nw, lw, to);
      total++; if (ns !== 2) $display("FAIL sb_stall_cycles got %0d want 2", ns); else pass_cnt++;
      total++; if (nw !== 1 || lw !== 32'h1199AABB) $display("FAIL sb_write got %0d x %h want 1 x 1199aabb", nw, lw); else pass_cnt++;
      total++; if (d !== 1'b1 || m !== 1'b0) $display("FAIL sb_done got %b%b want 10", d, m); else pass_cnt++;
      model(1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h0, e_d, e_m, es, ew);
      do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h0, d, m, ns, nw, lw, to);
      total++; if (rd_data !== 32'h1199AABB) $display("FAIL lw_after_sb got %h want 1199aabb", rd_data); else pass_cnt++;
      @(negedge clk);
      preload(3, 32'h8899AABB);
      model(1'b1, 1'b0, 2'd1, 1'b0, 32'h0C, 32'hCAFE, e_d, e_m, es, ew);
      do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0C, 32'hCAFE, d, m, ns, nw, lw, to);
      total++; if (mem[3] !== 32'h8899CAFE) $display("FAIL sh_word got %h want 8899cafe", mem[3]); else pass_cnt++;
      model(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, e_d, e_m, es, ew);
      do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, d, m, ns, nw, lw, to);
      total++; if (mem[0] !== 32'hDEADBEEF || ns !== 0) $display("FAIL sw_wrap got %h stall %0d want deadbeef stall 0", mem[0], ns); else pass_cnt++;
   endtask

   task automatic test_misaligned();
      logic d, m, e_d, e_m, to;
      int ns, nw, es, ew;
      logic [31:0] lw, prev_rd, prev_w;
      prev_rd = rd_data;
      prev_w  = mem[3];
      model(1'b0, 1'b1, 2'd2, 1'b0, 32'h0E, 32'h0, e_d, e_m, es, ew);
      do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h0E, 32'h0, d, m, ns, nw, lw, to);
      total++; if (d !== 1'b1 || m !== 1'b1) $display("FAIL mis_lw_flags got %b%b want 11", d, m); else pass_cnt++;
      total++; if (rd_data !== prev_rd) $display("FAIL mis_lw_rd got %h want %h", rd_data, prev_rd); else pass_cnt++;
      model(1'b1, 1'b0, 2'd1, 1'b0, 32'h0D, 32'hFFFF, e_d, e_m, es, ew);
      do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0D, 32'hFFFF, d, m, ns, nw, lw, to);
      total++; if (d !== 1'b1 || m !== 1'b1 || nw !== 0 || ns !== 0) $display("FAIL mis_sh got done %b mis %b wr %0d stall %0d want 1 1 0 0", d, m, nw, ns); else pass_cnt++;
      total++; if (mem[3] !== prev_w || rd_data !== prev_rd) $display("FAIL mis_sh_state got %h/%h want %h/%h", mem[3], rd_data, prev_w, prev_rd); else pass_cnt++;
   endtask

   // Abort a byte store in its write cycle, once by flush and once by reset.
   task automatic test_abort_rmw(input logic use_reset);
      logic [31:0] prev_rd;
      @(negedge clk);
      preload(3, 32'h8899AABB);
      prev_rd = rd_data;
      req_valid = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0; size = 2'd0; uns = 1'b0;
      addr = 32'h0F; wr_data = 32'h11;
      #1;
      total++; if (stall !== 1'b1) $display("FAIL abort%0d_first_stall got %b want 1", use_reset, stall); else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      if (use_reset) rst = 1'b1; else flush = 1'b1;
      #1;
      total++; if (mem_wr_rd !== 1'b0) $display("FAIL abort%0d_wr_rd got %b want 0", use_reset, mem_wr_rd); else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; req_valid = 1'b0; mem_wr = 1'b0;
      #1;
      total++; if (done !== 1'b0 || stall !== 1'b0) $display("FAIL abort%0d_done got %b stall %b want 0 0", use_reset, done, stall); else pass_cnt++;
      total++; if (mem[3] !== 32'h8899AABB) $display("FAIL abort%0d_word got %h want 8899aabb", use_reset, mem[3]); else pass_cnt++;
      if (use_reset) ref_rd = 32'h0;
      total++; if (rd_data !== (use_reset ? 32'h0 : prev_rd)) $display("FAIL abort%0d_rd got %h want %h", use_reset, rd_data, use_reset ? 32'h0 : prev_rd); else pass_cnt++;
   endtask

   task automatic test_flush_idle();
      logic [31:0] prev_rd;
      prev_rd = rd_data;
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; mem_wr = 1'b0; mem_rd = 1'b1; size = 2'd2; addr = 32'h0C;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0; mem_rd = 1'b0;
      #1;
      total++; if (done !== 1'b0 || rd_data !== prev_rd) $display("FAIL flush_idle got done %b rd %h want 0 %h", done, rd_data, prev_rd); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic e_d, e_m;
      int es, ew;
      @(negedge clk);
      preload(3, 32'h8899AABB);
      model(1'b1, 1'b0, 2'd0, 1'b0, 32'h0D, 32'h5A, e_d, e_m, es, ew);
      model(1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h0, e_d, e_m, es, ew);
      @(negedge clk);
      req_valid = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0; size = 2'd0; addr = 32'h0D; wr_data = 32'h5A;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      mem_wr = 1'b0; mem_rd = 1'b1; size = 2'd2; addr = 32'h0C;
      #1;
      total++; if (done !== 1'b1 || stall !== 1'b0) $display("FAIL b2b_sb_done got %b stall %b want 1 0", done, stall); else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; mem_rd = 1'b0;
      #1;
      total++; if (rd_data !== 32'h88995ABB || ref_rd !== 32'h88995ABB) $display("FAIL b2b_lw got %h want 88995abb", rd_data); else pass_cnt++;
      total++; if (done !== 1'b1) $display("FAIL b2b_lw_done got %b want 1", done); else pass_cnt++;
   endtask

   task automatic test_random(input int n);
      logic d, m, e_d, e_m, to, w, r, u;
      logic [1:0] sz;
      logic [31:0] a, wd, lw;
      int ns, nw, es, ew, bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 3) != 0);
         sz = 2'($urandom_range(0, 3));
         u = 1'($urandom_range(0, 1));
         a = $urandom;
         wd = $urandom;
         model(w, r, sz, u, a, wd, e_d, e_m, es, ew);
         do_access(w, r, sz, u, a, wd, d, m, ns, nw, lw, to);
         total++;
         if (d !== e_d || m !== e_m || ns !== es || nw !== ew || rd_data !== ref_rd || to !== 1'b0) begin
            $display("FAIL rand%0d got d%b m%b s%0d w%0d rd %h want d%b m%b s%0d w%0d rd %h (wr%b rd%b sz%0d a %h)",
                     i, d, m, ns, nw, rd_data, e_d, e_m, es, ew, ref_rd, w, r, sz, a);
         end else pass_cnt++;
      end
      for (int k = 0; k < 32; k++) begin
         if (mem[k] !== ref_mem[k]) begin
            bad++;
            $display("FAIL rand_mem[%0d] got %h want %h", k, mem[k], ref_mem[k]);
         end
      end
      total++; if (bad != 0) $display("FAIL rand_mem_words got %0d bad want 0", bad); else pass_cnt++;
   endtask

   initial begin
      logic [31:0] v;
      for (int k = 0; k < 32; k++) begin
         v = $urandom;
         mem[k] <= v;
         ref_mem[k] = v;
      end
      ref_rd = 32'h0;
      test_reset();
      test_loads();
      test_sub_store();
      test_misaligned();
      test_abort_rmw(1'b0);
      test_abort_rmw(1'b1);
      test_flush_idle();
      test_back_to_back();
      test_random(300);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
